serial_borrow_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor. Computes diff = a - b - b_in over WIDTH clock cycles, one bit per cycle, LSB first, through a single borrow flip-flop.
- It is the subtract-direction counterpart to the team's ripple carry adders.
- Used in area-constrained datapaths where a multi-cycle latency is acceptable.
- A start/busy/done handshake frames each operation.

---
 rtl/serial_borrow_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: bit-serial ripple-borrow subtractor.
// Computes diff = a - b - b_in one bit per clock cycle, LSB first, through a
// single borrow flop. Each operation is framed by a start/busy/done handshake.
// The optional signed-overflow output is enabled with macro SERIAL_SUB_OVF_EN.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor difference bit.
  function automatic logic sub_diff_bit(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Full-subtractor borrow-out: borrow when y alone exceeds x, or x == y and a borrow arrives.
  function automatic logic sub_borrow_bit(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign d_bit   = sub_diff_bit(a_sh[0], b_sh[0], br);
  assign br_next = sub_borrow_bit(a_sh[0], b_sh[0], br);
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign r_next  = {d_bit, r_sh[WIDTH-1:1]};

  // Handshake FSM plus the serial datapath; result registers change only on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= b_in;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          r_sh <= r_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff   <= r_next;
            borrow <= br_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: operand signs differ and the result sign departs from a.
            ovf    <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
`endif
          end
        end
        DONE: begin
          // start is deliberately ignored here so the done pulse is always one cycle.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor: directed vectors with hand-computed results.
// Stimulus pushes expected results into per-instance queues; monitors pop and
// compare on every done pulse. A 4-bit and an 8-bit instance share clk/rst.
module tb_serial_borrow_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       bin4, bin8;
  logic       borrow4, borrow8, busy4, busy8, done4, done8;
  logic       ovf4, ovf8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt4 = 0;
  int   done_cnt8 = 0;

  serial_borrow_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .b_in(bin4),
    .diff(diff4), .borrow(borrow4), .busy(busy4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf4),
`endif
    .done(done4)
  );

  serial_borrow_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .diff(diff8), .borrow(borrow8), .busy(busy8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf8),
`endif
    .done(done8)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (busy4 && done4) chk("busy_done_overlap4", 32'(1), 32'(0));
    if (done4 === 1'b1) begin
      done_cnt4++;
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'(1), 32'(0));
      end else begin
        e4 = q4.pop_front();
        chk("diff4", 32'(diff4), e4.diff);
        chk("borrow4", 32'(borrow4), 32'(e4.borrow));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf4", 32'(ovf4), 32'(e4.ovf));
`endif
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (busy8 && done8) chk("busy_done_overlap8", 32'(1), 32'(0));
    if (done8 === 1'b1) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'(1), 32'(0));
      end else begin
        e8 = q8.pop_front();
        chk("diff8", 32'(diff8), e8.diff);
        chk("borrow8", 32'(borrow8), 32'(e8.borrow));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf8", 32'(ovf8), 32'(e8.ovf));
`endif
      end
    end
  end

  // Drive one request; returns #1 after the accepting edge N.
  task automatic kick(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    e.diff = 32'(ed);
    e.borrow = eb;
    e.ovf = eo;
    if (w8) q8.push_back(e); else q4.push_back(e);
    @(negedge clk);
    if (w8) begin a8 = a; b8 = b; bin8 = bi; start8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bi; start4 = 1'b1; end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
    // Operands may change freely after acceptance.
    a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    chk(w8 ? "busy_after_start8" : "busy_after_start4", 32'(w8 ? busy8 : busy4), 32'(1));
  endtask

  // Wait for done with a bounded budget, then check latency and the one-cycle pulse.
  task automatic wait_done(input bit w8, input int width, input int elapsed);
    int n;
    n = elapsed;
    while (!(w8 ? done8 : done4) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(w8 ? "latency8" : "latency4", 32'(n), 32'(width));
    @(posedge clk);
    #1;
    chk(w8 ? "done_pulse8" : "done_pulse4", 32'(w8 ? done8 : done4), 32'(0));
    chk(w8 ? "idle_busy8" : "idle_busy4", 32'(w8 ? busy8 : busy4), 32'(0));
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    #12;
    chk("rst_diff4", 32'(diff4), 32'(0));
    chk("rst_borrow4", 32'(borrow4), 32'(0));
    chk("rst_busy4", 32'(busy4), 32'(0));
    chk("rst_done4", 32'(done4), 32'(0));
    chk("rst_diff8", 32'(diff8), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // 9 - 3 = 6
    kick(1'b0, 8'd9, 8'd3, 1'b0, 8'h6, 1'b0, 1'b1);
    wait_done(1'b0, 4, 0);
    // 3 - 9 = -6 -> 0xA with borrow
    kick(1'b0, 8'd3, 8'd9, 1'b0, 8'hA, 1'b1, 1'b1);
    wait_done(1'b0, 4, 0);
    // 0 - 0 - 1 -> 0xF with borrow
    kick(1'b0, 8'd0, 8'd0, 1'b1, 8'hF, 1'b1, 1'b0);
    wait_done(1'b0, 4, 0);

    // Second start two cycles into an operation is ignored.
    dc = done_cnt4;
    kick(1'b0, 8'd5, 8'd1, 1'b0, 8'h4, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    chk("hold_diff_in_shift", 32'(diff4), 32'(4'hF));
    chk("busy_during_ignored", 32'(busy4), 32'(1));
    wait_done(1'b0, 4, 2);
    chk("single_done", 32'(done_cnt4 - dc), 32'(1));
    // Back-to-back at minimum issue interval: 2 - 5 - 1 = -4 -> 0xC
    kick(1'b0, 8'd2, 8'd5, 1'b1, 8'hC, 1'b1, 1'b0);
    wait_done(1'b0, 4, 0);

    // Reset in the second SHIFT cycle aborts the operation.
    dc = done_cnt4;
    kick(1'b0, 8'd12, 8'd4, 1'b0, 8'h8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_diff", 32'(diff4), 32'(0));
    chk("abort_borrow", 32'(borrow4), 32'(0));
    chk("abort_busy", 32'(busy4), 32'(0));
    q4.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt4 - dc), 32'(0));
    chk("abort_idle_diff", 32'(diff4), 32'(0));
    kick(1'b0, 8'd12, 8'd4, 1'b0, 8'h8, 1'b0, 1'b0);
    wait_done(1'b0, 4, 0);

    // Signed overflow vectors (ovf compared only when the feature is built in).
    kick(1'b0, 8'd7, 8'd8, 1'b0, 8'hF, 1'b1, 1'b1);
    wait_done(1'b0, 4, 0);
    kick(1'b0, 8'd6, 8'd2, 1'b0, 8'h4, 1'b0, 1'b0);
    wait_done(1'b0, 4, 0);

    // 8-bit instance.
    kick(1'b1, 8'd255, 8'd255, 1'b0, 8'd0, 1'b0, 1'b0);
    wait_done(1'b1, 8, 0);
    kick(1'b1, 8'd0, 8'd1, 1'b0, 8'd255, 1'b1, 1'b0);
    wait_done(1'b1, 8, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("q4_drained", 32'(q4.size()), 32'(0));
    chk("q8_drained", 32'(q8.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
